// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational winner select. Round-robin from last_i+1, or fixed
// lowest-index priority when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  input  logic               rr_en_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic             rr_sel_s;
  logic             found_s;
  logic [IDX_W-1:0] cand_s;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign rr_sel_s = 1'b0;
`else
  assign rr_sel_s = rr_en_i;
`endif

  assign any_o = |req_i;

  // Scan candidates in priority order; the first requesting one wins.
  always_comb begin
    winner_o = '0;
    idx_o    = '0;
    found_s  = 1'b0;
    cand_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_sel_s) begin
        cand_s = IDX_W'((int'(last_i) + 1 + i) % NUM_REQ);
      end else begin
        cand_s = IDX_W'(i);
      end
      if (req_i[cand_s] && !found_s) begin
        winner_o[cand_s] = 1'b1;
        idx_o            = cand_s;
      end else begin
        idx_o = idx_o;
      end
      found_s = found_s | req_i[cand_s];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus among NUM_REQ requesters. Build option
// MEM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_ce,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_datai,
  input  logic [DATA_W-1:0]         mem_datao
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d, datai_q, datai_d;
  logic               ce_q, ce_d, we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic [NUM_REQ-1:0] win_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [IDX_W-1:0]   last_s;
  logic               any_s;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req_i   (req),
    .last_i  (last_s),
    .rr_en_i (1'b1),
    .winner_o(win_s),
    .idx_o   (win_idx_s),
    .any_o   (any_s)
  );

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign last_s = '0;
`else
  logic [IDX_W-1:0] last_q;

  // Most recent winner; reset so that requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else if (state_q == IDLE && any_s) begin
      last_q <= win_idx_s;
    end else begin
      last_q <= last_q;
    end
  end

  assign last_s = last_q;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      ce_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      datai_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      datai_q  <= datai_d;
    end
  end

  // Next-state and output decode; bus fields hold while ce is low.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    ce_d     = ce_q;
    we_d     = we_q;
    addr_d   = addr_q;
    datai_d  = datai_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          gnt_d   = win_s;
          owner_d = win_idx_s;
          ce_d    = 1'b1;
          we_d    = req_we[win_idx_s];
          addr_d  = req_addr[win_idx_s*ADDR_W +: ADDR_W];
          datai_d = req_wdata[win_idx_s*DATA_W +: DATA_W];
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = req_we[win_idx_s] ? WRITE : READ;
        end else begin
          ce_d = 1'b0;
        end
      end
      WRITE: begin
        ce_d    = 1'b0;
        state_d = IDLE;
      end
      READ: begin
        if (cnt_q == '0) begin
          rdata_d           = mem_datao;
          rvalid_d[owner_q] = 1'b1;
          ce_d              = 1'b0;
          state_d           = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        ce_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_ce    = ce_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_datai = datai_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the driver pushes expected grants and read
// data into queues, a negedge monitor pops and compares as the DUT responds.
module tb_mem_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int RD_LAT  = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req, req_we, gnt, rvalid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]         rdata, mem_datai, mem_datao;
  logic                      mem_ce, mem_we;
  logic [ADDR_W-1:0]         mem_addr;

  logic [7:0] mem_arr [256];
  logic [7:0] exp_mem [256];

  typedef struct {
    int         r;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } gnt_exp_t;

  typedef struct {
    int         r;
    logic [7:0] data;
  } rd_exp_t;

  gnt_exp_t gq[$];
  rd_exp_t  rq[$];
  gnt_exp_t me;
  rd_exp_t  mr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_gnt_cyc = 0;
  bit wr_chk = 1'b0;

  mem_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_datai(mem_datai), .mem_datao(mem_datao)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Simple synchronous memory behind the bus.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) mem_arr[mem_addr] <= mem_datai;
      else        mem_datao <= mem_arr[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every grant and read return against the queues.
  always @(negedge clk) begin
    if (wr_chk) begin
      chk("write_ce_one_cycle", {31'd0, mem_ce}, 32'd0);
      wr_chk = 1'b0;
    end
    if (gnt != '0) begin
      if (gq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_gnt: got %b expected none", gnt);
      end else begin
        me = gq.pop_front();
        chk("gnt_onehot", {30'd0, gnt}, 32'd1 << me.r);
        chk("gnt_ce", {31'd0, mem_ce}, 32'd1);
        chk("gnt_we", {31'd0, mem_we}, {31'd0, me.we});
        chk("gnt_addr", {24'd0, mem_addr}, {24'd0, me.addr});
        if (me.we) begin
          chk("gnt_datai", {24'd0, mem_datai}, {24'd0, me.data});
          wr_chk = 1'b1;
        end
        last_gnt_cyc = cyc;
      end
    end
    if (rvalid != '0) begin
      if (rq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rvalid: got %b expected none", rvalid);
      end else begin
        mr = rq.pop_front();
        chk("rvalid_onehot", {30'd0, rvalid}, 32'd1 << mr.r);
        chk("rdata", {24'd0, rdata}, {24'd0, mr.data});
        chk("read_latency", cyc - last_gnt_cyc, RD_LAT);
        chk("rvalid_ce_low", {31'd0, mem_ce}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r, input logic we, input logic [7:0] a,
                       input logic [7:0] d, input bit exp_rd,
                       output int g_cyc, output int polls);
    req_we[r]           = we;
    req_addr[r*8 +: 8]  = a;
    req_wdata[r*8 +: 8] = d;
    req[r]              = 1'b1;
    gq.push_back('{r, we, a, d});
    if (we) exp_mem[a] = d;
    else if (exp_rd) rq.push_back('{r, exp_mem[a]});
    polls = 0;
    do begin
      tick();
      polls++;
    end while (!gnt[r] && polls < 20);
    if (!gnt[r]) begin
      tests++; fails++;
      $display("FAIL gnt_timeout: requester %0d got no gnt in %0d cycles", r, polls);
    end
    g_cyc = cyc;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_gnt"},    {30'd0, gnt},       32'd0);
    chk({pfx, "_rvalid"}, {30'd0, rvalid},    32'd0);
    chk({pfx, "_rdata"},  {24'd0, rdata},     32'd0);
    chk({pfx, "_ce"},     {31'd0, mem_ce},    32'd0);
    chk({pfx, "_we"},     {31'd0, mem_we},    32'd0);
    chk({pfx, "_addr"},   {24'd0, mem_addr},  32'd0);
    chk({pfx, "_datai"},  {24'd0, mem_datai}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, p, prev, n, polls;
    int ord [4];
    logic [7:0] bd [8];
    bd = '{8'h3C, 8'hA7, 8'h01, 8'hFE, 8'h58, 8'h92, 8'h6D, 8'hC4};
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;

    reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Reset during a read: access abandoned, no rvalid afterwards.
    issue(0, 1'b0, 8'd7, 8'd0, 1'b0, g, p);
    req[0] = 1'b0;
    reset = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    reset = 1'b0;
    repeat (4) tick();
    issue(1, 1'b1, 8'h30, 8'h77, 1'b0, g, p);
    req[1] = 1'b0;
    chk("post_reset_latency", p, 1);
    repeat (2) tick();

    // Collision: both held, four write grants.
`ifdef MEM_ARB_FIXED_PRIO_EN
    ord = '{0, 0, 0, 0};
`else
    ord = '{0, 1, 0, 1};
`endif
    for (int k = 0; k < 4; k++) begin
      gq.push_back('{ord[k], 1'b1, (ord[k] != 0) ? 8'd20 : 8'd10,
                     (ord[k] != 0) ? 8'h22 : 8'h11});
      if (ord[k] != 0) exp_mem[20] = 8'h22;
      else             exp_mem[10] = 8'h11;
    end
    req_we = 2'b11; req_addr = {8'd20, 8'd10}; req_wdata = {8'h22, 8'h11};
    req = 2'b11;
    n = 0; prev = -1; polls = 0;
    while (n < 4 && polls < 40) begin
      tick();
      polls++;
      if (gnt != '0) begin
        n++;
        if (prev >= 0) chk("coll_spacing", cyc - prev, 2);
        prev = cyc;
      end
    end
    req = '0;
    chk("coll_grants", n, 4);
    repeat (2) tick();

    // Single write then read-back.
    issue(0, 1'b1, 8'd3, 8'hA5, 1'b0, g, p);
    req[0] = 1'b0;
    chk("wr_latency", p, 1);
    tick();
    issue(0, 1'b0, 8'd3, 8'd0, 1'b1, g, p);
    req[0] = 1'b0;
    chk("rd_latency", p, 1);
    repeat (4) tick();

    // Burst: 8 back-to-back writes then 8 reads from requester 1.
    for (int i = 0; i < 8; i++) begin
      issue(1, 1'b1, 8'(i), bd[i], 1'b0, g, p);
      if (i > 0) chk("burst_wr_gap", g - prev, 2);
      prev = g;
    end
    for (int i = 0; i < 8; i++) begin
      issue(1, 1'b0, 8'(i), 8'd0, 1'b1, g, p);
      chk("burst_rd_gap", g - prev, (i == 0) ? 2 : RD_LAT + 1);
      prev = g;
    end
    req[1] = 1'b0;
    repeat (5) tick();

    // Request from 0 during requester 1's read is held off until IDLE.
    issue(1, 1'b0, 8'd3, 8'd0, 1'b1, g, p);
    req[1] = 1'b0;
    req_we[0] = 1'b1; req_addr[7:0] = 8'd5; req_wdata[7:0] = 8'h3C;
    req[0] = 1'b1;
    gq.push_back('{0, 1'b1, 8'd5, 8'h3C});
    exp_mem[5] = 8'h3C;
    tick();
    chk("ign_no_gnt_read", {30'd0, gnt}, 32'd0);
    tick();
    chk("ign_rvalid1", {30'd0, rvalid}, 32'd2);
    chk("ign_no_gnt_rvalid", {30'd0, gnt}, 32'd0);
    tick();
    chk("ign_gnt0_idle", {30'd0, gnt}, 32'd1);
    req[0] = 1'b0;
    tick();
    issue(0, 1'b0, 8'd5, 8'd0, 1'b1, g, p);
    req[0] = 1'b0;
    repeat (5) tick();

    chk("gnt_queue_empty", gq.size(), 0);
    chk("rd_queue_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
